// File: rtl/osc_meas_pkg.sv
`default_nettype none
// ============================================================================
// Module   : osc_meas_pkg
// Brief    : Shared types, defaults and helpers for the oscillator measurement
//            sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package osc_meas_pkg;

    localparam int DEF_CNT_W    = 16;
    localparam int DEF_OUT_W    = 8;
    localparam int DEF_GSEL_MAX = 11;
    localparam int GATE_W       = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        GATE   = 3'd2,
        SETTLE = 3'd3,
        REPORT = 3'd4
    } meas_state_t;

    // Gate length in clk cycles; callers clip gsel first so the shift never
    // leaves the 16-bit range.
    function automatic logic [GATE_W-1:0] gate_len(input logic [3:0] gsel);
        return 16'd16 << gsel;
    endfunction

    function automatic logic [7:0] sat8(input logic [31:0] x);
        return (x > 32'd255) ? 8'hFF : x[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/osc_gate_timer.sv
`default_nettype none
// ============================================================================
// Module   : osc_gate_timer
// Brief    : Loadable down-counter with a zero flag, times the counting gate.
// Revision : 1.0 - initial release
// ============================================================================
module osc_gate_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/osc_meas_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : osc_meas_sequencer
// Brief    : Clear/gate/settle/report sequencer for the edge-counter path with
//            saturated 8-bit result and valid/ready handoff.
//            Define MEAS_AVG_EN to average four gate passes per result.
// Revision : 1.0 - initial release
// ============================================================================
module osc_meas_sequencer
    import osc_meas_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int GSEL_MAX = DEF_GSEL_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             continuous,
    input  logic [3:0]       gate_sel,
    output logic             cnt_clr,
    output logic             cnt_en,
    input  logic [CNT_W-1:0] cnt_val,
    input  logic             cnt_ovf,
    output logic [OUT_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overflow,
    output logic             busy
);

    localparam logic [3:0] c_gsel_max = 4'(GSEL_MAX);

    meas_state_t       r_state;
    meas_state_t       w_state_next;
    logic [3:0]        r_gsel;
    logic [3:0]        w_gsel_eff;
    logic [3:0]        w_gsel_cur;
    logic [GATE_W-1:0] w_gate_load;
    logic              w_timer_load;
    logic              w_timer_dec;
    logic              w_timer_zero;
    logic              w_last_pass;
    logic [OUT_W-1:0]  r_result;
    logic [OUT_W-1:0]  w_meas;
    logic              r_overflow;
    logic              w_meas_ovf;

    assign w_gsel_eff  = (gate_sel > c_gsel_max) ? c_gsel_max : gate_sel;
    // Gate length in force: fresh value while latching, held value otherwise.
    assign w_gsel_cur  = (r_state == CLEAR) ? w_gsel_eff : r_gsel;
    assign w_gate_load = gate_len(w_gsel_cur) - 1'b1;

    osc_gate_timer #(
        .WIDTH (GATE_W)
    ) u_gate_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_timer_load),
        .i_load_val (w_gate_load),
        .i_dec      (w_timer_dec),
        .o_zero     (w_timer_zero)
    );

`ifdef MEAS_AVG_EN
    logic [1:0]  r_pass;
    logic [17:0] r_acc;
    logic [17:0] w_acc_sum;
    logic        r_ovf_any;
    logic        w_ovf_any;
    logic [15:0] w_avg;

    // Pass 0 restarts the accumulation, so no explicit clear is needed.
    assign w_acc_sum   = ((r_pass == 2'd0) ? 18'd0 : r_acc)
                       + (cnt_ovf ? 18'h0FFFF : 18'(cnt_val));
    assign w_ovf_any   = ((r_pass != 2'd0) && r_ovf_any) || cnt_ovf;
    assign w_avg       = 16'(w_acc_sum >> 2);
    assign w_last_pass = (r_pass == 2'd3);
    assign w_meas      = OUT_W'(sat8(32'(w_avg)));
    assign w_meas_ovf  = w_ovf_any || (w_avg > 16'd255);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pass    <= 2'd0;
            r_acc     <= 18'd0;
            r_ovf_any <= 1'b0;
        end else if (r_state == SETTLE) begin
            r_pass    <= r_pass + 2'd1;
            r_acc     <= w_acc_sum;
            r_ovf_any <= w_ovf_any;
        end
    end
`else
    assign w_last_pass = 1'b1;
    assign w_meas      = cnt_ovf ? '1 : OUT_W'(sat8(32'(cnt_val)));
    assign w_meas_ovf  = cnt_ovf || (32'(cnt_val) > 32'd255);
`endif

    always_comb begin
        w_state_next = r_state;
        w_timer_load = 1'b0;
        w_timer_dec  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_next = CLEAR;
            end
            CLEAR: begin
                w_timer_load = 1'b1;
                w_state_next = GATE;
            end
            GATE: begin
                w_timer_dec = 1'b1;
                if (w_timer_zero) w_state_next = SETTLE;
            end
            SETTLE: begin
                w_state_next = w_last_pass ? REPORT : CLEAR;
            end
            REPORT: begin
                if (result_ready) w_state_next = continuous ? CLEAR : IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gsel     <= 4'd0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == CLEAR) r_gsel <= w_gsel_eff;
            // Result is held across handshakes so the display never blanks.
            if ((r_state == SETTLE) && w_last_pass) begin
                r_result   <= w_meas;
                r_overflow <= w_meas_ovf;
            end
        end
    end

    assign cnt_clr      = (r_state == CLEAR);
    assign cnt_en       = (r_state == GATE);
    assign result_valid = (r_state == REPORT);
    assign busy         = (r_state != IDLE);
    assign result       = r_result;
    assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: doc/osc_meas_sequencer.md
Name: osc_meas_sequencer

Overview:
- Control FSM for the oscillator-tester measurement path. It sequences an external edge counter that counts rising edges of the synchronised `sig_in` through clear, gate, settle and report phases.
- It converts the raw count into a saturated 8-bit measurement for `uo_out` and hands it over with a valid/ready handshake.
- It supports single-shot and free-running (continuous) modes.
- It sits between the top-level I/O decode (`uio_in` config bits) and the counter datapath.

Parameters:
- CNT_W, 16, width of the external edge counter value.
- OUT_W, 8, width of the reported measurement.
- GSEL_MAX, 11, maximum effective `gate_sel`; larger inputs are clipped to this value.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse requesting a measurement. Ignored while `busy`=1.
- continuous  in  1  1 = restart automatically after each handshake completes. Sampled in REPORT.
- gate_sel  in  4  gate length select. Latched in CLEAR.
- cnt_clr  out  1  clears the external counter.
- cnt_en  out  1  enables edge counting in the external counter.
- cnt_val  in  CNT_W  external counter value.
- cnt_ovf  in  1  external counter wrapped during the gate.
- result  out  OUT_W  saturated measurement.
- result_valid  out  1  measurement available.
- result_ready  in  1  consumer accepts the measurement.
- overflow  out  1  `result` was saturated. Qualified by `result_valid`; held with `result`.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values: all outputs 0; state = IDLE; gate timer = 0; latched `gate_sel` = 0.
- Gate length: G = 16 << min(gate_sel, GSEL_MAX) clk cycles, i.e. 16 to 32768. Gate timer is 16 bits wide.
- States:
  - IDLE: `busy`=0. If `start`=1 at an edge, next state is CLEAR.
  - CLEAR: one cycle. `cnt_clr`=1; latch the effective `gate_sel`; load timer with G-1. Next state is GATE.
  - GATE: `cnt_en`=1 for exactly G cycles. Timer decrements each cycle; on the cycle the timer is 0, next state is SETTLE.
  - SETTLE: one cycle with `cnt_en`=0, absorbing counter pipeline delay. Sample `cnt_val` and `cnt_ovf`:
    - `result` = `cnt_val` if `cnt_val` ≤ 255 and `cnt_ovf`=0; otherwise 255.
    - `overflow` = 1 when saturated, else 0.
    - Next state is REPORT.
  - REPORT: `result_valid`=1. Stay until `result_valid` and `result_ready` are both 1 at an edge. On that handshake:
    - `continuous`=1: next state is CLEAR.
    - `continuous`=0: next state is IDLE.
- Latency: `start` sampled at edge k → CLEAR in cycle k+1 → GATE in cycles k+2 .. k+1+G → SETTLE in cycle k+2+G → `result_valid` first high in cycle k+3+G.
- `result` and `overflow` hold their values after the handshake until the next SETTLE, so `uo_out` is never blanked between measurements.
- `result_valid` deasserts in the cycle after the handshake.
- `start` during a non-IDLE state is dropped and is not queued. This includes `start` in the same cycle as a REPORT handshake.
- `gate_sel` changes outside CLEAR have no effect on the gate in progress.
- `rst` mid-operation: the FSM returns to IDLE next cycle, all outputs go to 0, and the pending result is discarded.
- `result_ready` high in IDLE is ignored.

Optional Feature:
- Macro: MEAS_AVG_EN.
- Defined:
  - The FSM runs 4 back-to-back CLEAR/GATE/SETTLE passes per result.
  - A 2-bit pass counter and an 18-bit accumulator are added. The accumulator adds `cnt_val`, or 0xFFFF if `cnt_ovf`=1.
  - `result` = saturate8(acc >> 2).
  - `overflow` = 1 if any pass had `cnt_ovf` set, or if the average exceeds 255.
  - Result latency becomes 4·(G+2)+1 cycles after `start`. REPORT is entered only after the 4th SETTLE.
- Undefined: a single pass per result, exactly as described in Behaviour.

Decomposition:
- Package `osc_meas_pkg`:
  - state enum (IDLE, CLEAR, GATE, SETTLE, REPORT);
  - CNT_W and OUT_W defaults;
  - GSEL_MAX;
  - function `gate_len(gsel)`;
  - function `sat8(x)`.
- One sub-module, `osc_gate_timer`: loadable 16-bit down-counter with a zero flag. The FSM and the saturation logic stay in the top module.

Test Plan:
- Single shot: `gate_sel`=0, `start` pulse, `cnt_val`=42 at SETTLE, `result_ready`=1 → `cnt_en` high exactly 16 cycles; `result_valid` at cycle k+19; `result`=42; `overflow`=0; FSM returns to IDLE and `busy`=0.
- Saturation: `cnt_val`=300, then repeat with `cnt_val`=10 and `cnt_ovf`=1 → `result`=255 with `overflow`=1 in both cases.
- Backpressure and continuous mode: hold `result_ready`=0 for 50 cycles → `result_valid` and `result` stable throughout. With `continuous`=1, raising `result_ready` → CLEAR on the next cycle and `cnt_clr` pulses once.
- Gate clipping: `gate_sel`=15 → `cnt_en` high for 32768 cycles. Changing `gate_sel` mid-gate → length unchanged.
- Reset and start-ignore: assert `rst` in GATE → next cycle all outputs 0 and state IDLE. A `start` pulse while `busy` → no extra measurement produced.
- MEAS_AVG_EN: passes with `cnt_val` = 100, 104, 96, 100 → one `result_valid` carrying `result`=100; `cnt_clr` pulses 4 times.
